// File: rtl/selector_2bits_reg.sv
// Registered 4-to-1 word selector: a 2-bit code picks one of four operands,
// which is presented on result one clock later, with valid marking post-reset data.
module selector_2bits_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] number1,
    input  logic [WIDTH-1:0] number2,
    input  logic [WIDTH-1:0] number3,
    input  logic [WIDTH-1:0] number4,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    logic [WIDTH-1:0] w_selected;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    // Full decode of the selection code; every code maps to one operand.
    always_comb begin
        w_selected = number1;
        unique case (select)
            2'd0: w_selected = number1;
            2'd1: w_selected = number2;
            2'd2: w_selected = number3;
            2'd3: w_selected = number4;
        endcase
    end

    // Output register; reset wins over selection and discards any prior value.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_result <= w_selected;
            r_valid  <= 1'b1;
        end
    end

    assign result = r_result;
    assign valid  = r_valid;

endmodule

// File: tb/tb_selector_2bits_reg.sv
// Self-checking bench for selector_2bits_reg: 8-bit and 16-bit instances share
// clock, reset and select; results are compared to an array-indexed reference.
module tb_selector_2bits_reg;

    logic        clk;
    logic        Reset;
    logic [1:0]  select;
    logic [7:0]  n8_1, n8_2, n8_3, n8_4;
    logic [15:0] n16_1, n16_2, n16_3, n16_4;
    logic [7:0]  result8;
    logic [15:0] result16;
    logic        valid8, valid16;

    // Reference operand tables, indexed by the selection code.
    logic [7:0]  ops8  [4];
    logic [15:0] ops16 [4];

    int errors = 0;
    int checks = 0;

    selector_2bits_reg #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .Reset   (Reset),
        .number1 (n8_1),
        .number2 (n8_2),
        .number3 (n8_3),
        .number4 (n8_4),
        .select  (select),
        .result  (result8),
        .valid   (valid8)
    );

    selector_2bits_reg #(.WIDTH(16)) u_dut16 (
        .clk     (clk),
        .Reset   (Reset),
        .number1 (n16_1),
        .number2 (n16_2),
        .number3 (n16_3),
        .number4 (n16_4),
        .select  (select),
        .result  (result16),
        .valid   (valid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it if the observed value differs.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle from the operand tables, then check both instances after the edge.
    task automatic step(input logic rst, input logic [1:0] sel, input string tag);
        logic [7:0]  exp8;
        logic [15:0] exp16;
        @(negedge clk);
        Reset  = rst;
        select = sel;
        n8_1 = ops8[0];  n8_2 = ops8[1];  n8_3 = ops8[2];  n8_4 = ops8[3];
        n16_1 = ops16[0]; n16_2 = ops16[1]; n16_3 = ops16[2]; n16_4 = ops16[3];
        exp8  = rst ? 8'h00  : ops8[sel];
        exp16 = rst ? 16'h0000 : ops16[sel];
        @(posedge clk);
        #1;
        check_val({tag, ".result8"},  32'(result8),  32'(exp8));
        check_val({tag, ".valid8"},   32'(valid8),   32'(!rst));
        check_val({tag, ".result16"}, 32'(result16), 32'(exp16));
        check_val({tag, ".valid16"},  32'(valid16),  32'(!rst));
    endtask

    task automatic randomize_ops16();
        for (int k = 0; k < 4; k++) ops16[k] = 16'($urandom);
    endtask

    initial begin
        logic [1:0] cnt;
        Reset  = 1'b1;
        select = 2'd0;
        n8_1 = '0; n8_2 = '0; n8_3 = '0; n8_4 = '0;
        n16_1 = '0; n16_2 = '0; n16_3 = '0; n16_4 = '0;

        // Reset hold with operands 1..4 and arbitrary select.
        ops8[0] = 8'h01; ops8[1] = 8'h02; ops8[2] = 8'h03; ops8[3] = 8'h04;
        randomize_ops16();
        step(1'b1, 2'($urandom), "reset_hold0");
        step(1'b1, 2'($urandom), "reset_hold1");

        // Rotation driven by a free-running counter, wrapping 3 -> 0.
        cnt = 2'd0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, cnt, "rotate");
            cnt = cnt + 2'd1;
        end

        // Mid-stream reset while select = 3, then resume from current select.
        step(1'b0, 2'd2, "pre_midrst");
        step(1'b1, 2'd3, "midrst");
        step(1'b0, 2'd0, "post_midrst0");
        step(1'b0, 2'd1, "post_midrst1");

        // Static select = 2, number3 stepping; other operands churn randomly.
        foreach (ops8[k]) ops8[k] = 8'($urandom);
        ops8[2] = 8'h00; step(1'b0, 2'd2, "static_00");
        ops8[0] = 8'($urandom); ops8[3] = 8'($urandom);
        ops8[2] = 8'hFF; step(1'b0, 2'd2, "static_FF");
        ops8[1] = 8'($urandom); ops8[3] = 8'($urandom);
        ops8[2] = 8'hA5; step(1'b0, 2'd2, "static_A5");

        // Bit isolation on 8 bits and full-width reproduction on 16 bits.
        ops8[0] = 8'hAA; ops8[1] = 8'h55; ops8[2] = 8'hF0; ops8[3] = 8'h0F;
        ops16[0] = 16'h1234; ops16[1] = 16'h5678; ops16[2] = 16'h9ABC; ops16[3] = 16'hDEF0;
        for (int s = 0; s < 4; s++) step(1'b0, 2'(s), "isolate");
        for (int s = 3; s >= 0; s--) step(1'b0, 2'(s), "isolate_rev");

        // Randomized traffic with occasional reset and simultaneous select/operand changes.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) ops8[k] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) randomize_ops16();
            step(($urandom_range(0, 15) == 0), 2'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
